text_writer: RTL and testbench
==============================

# text_writer

Write-side controller for the VGA character buffer, the 80×60 array of glyph indices that the character renderer scans out. It accepts an ASCII byte stream over a valid/ready handshake, keeps a cursor, and turns characters and control codes into single-cycle buffer writes. It clears the buffer after reset and on request, and clears each new line on line feed or wrap. Writes are issued only while the display side grants the buffer through `wr_allow`.

## Interface
- `CHARHRES`, 80, characters per row
- `CHARVRES`, 60, rows
- `SPC`, 8'h20, ASCII code of glyph index 0; glyph index = ASCII − `SPC`
- `clk`  in  1  pixel/system clock
- `rst`  in  1  reset, synchronous, active-high
- `char_valid`  in  1  `char_data` valid
- `char_data`  in  8  ASCII byte
- `char_ready`  out  1  byte accepted when `char_valid & char_ready`
- `clear_req`  in  1  one-cycle pulse; clear the whole buffer and home the cursor
- `wr_allow`  in  1  display grants the buffer write port this cycle
- `wr_en`  out  1  buffer write strobe
- `wr_addr`  out  13  row*`CHARHRES`+col
- `wr_data`  out  8  glyph index
- `cursor_x`  out  7  current column
- `cursor_y`  out  6  current row
- `busy`  out  1  high in any state except IDLE

## Operation
- States: CLEAR, IDLE, PUT, LINECLR.
- **CLEAR**: walks `wr_addr` from 0 to `CHARHRES*CHARVRES−1` writing 0. It advances only on cycles with `wr_en`. After the last write, cursor = (0,0) and the state goes to IDLE.
- **IDLE**: `char_ready=1` unless a clear is pending. On an accepted byte:
  - 0x20–0x7E: go to PUT with `wr_data = byte−SPC` at the cursor.
  - 0x0D (CR): col ← 0, stay in IDLE, no write.
  - 0x0A (LF): col ← 0, row ← row+1 (row `CHARVRES−1` wraps to 0), go to LINECLR.
  - 0x08 (BS): if col>0, col ← col−1 and go to PUT with `wr_data=0`. At col 0, nothing happens.
  - Any other byte is consumed and ignored.
- **PUT**: one write at the cursor. On the strobe, a printable byte advances col by 1. At col `CHARHRES−1` it instead behaves as LF: col 0, next row with wrap, then LINECLR. BS leaves the cursor in place. Otherwise the state returns to IDLE.
- **LINECLR**: writes 0 to all `CHARHRES` cells of the cursor row, col index 0..79, one per strobe. The cursor stays at (0,row). The state then returns to IDLE. No scrolling: the display wraps to the top row.
- `clear_req` handling:
  - In IDLE, it enters CLEAR next cycle. If `char_valid` is high in the same cycle, the clear wins and the byte is not accepted.
  - In PUT or LINECLR, it is latched and taken when the state would otherwise return to IDLE.
  - In CLEAR, it is ignored.
- `wr_en = (state ∈ {CLEAR,PUT,LINECLR}) & wr_allow`. `wr_addr` and `wr_data` are registered and stable while waiting for `wr_allow`.
- Address arithmetic:
  - Keep a `row_base` register (row*`CHARHRES`, 13 bits) that adds `CHARHRES` per row and resets to 0 on wrap. No multiplier.
  - `wr_addr = row_base + col`, 13 bits with no overflow; the maximum is 4799.

## Timing
- Reset values on the first edge with `rst=1`: state CLEAR, `wr_addr=0`, `wr_data=0`, cursor (0,0), `char_ready=0`, `busy=1`, pending clear 0. `wr_en` follows `wr_allow` from the cycle after reset.
- A reset mid-operation abandons any PUT, LINECLR or CLEAR and restarts the full CLEAR.
- Accept cycle N (printable byte, `wr_allow=1`): `wr_en` in cycle N+1, cursor updated at the end of N+1, `char_ready=1` in N+2. Sustained rate is one character per 2 cycles.
- `wr_allow` low stalls every write state indefinitely. Strobes happen only in granted cycles.
- Full clear takes 4800 granted cycles plus 1. LINECLR takes 80 granted cycles plus 1.

## Structure
- Shared package (`text_pkg`) holds:
  - `CHARHRES`, `CHARVRES`, `SPC`
  - ASCII constants: CR 8'h0D, LF 8'h0A, BS 8'h08
  - The 2-bit state enum
  - Buffer address width 13
- `text_pkg` is shared with the character renderer.
- Single module; no sub-module is warranted.

## Test plan
- Reset with `wr_allow=1` → exactly 4800 strobes, addr 0..4799, data 0. Then `busy=0`, `char_ready=1`, cursor (0,0).
- Send "Hi" → writes (addr 0, data 0x28), (addr 1, data 0x49). Cursor ends at (2,0).
- Cursor (5,3), send LF → 80 strobes at addr 320..399, data 0. Cursor ends at (0,4).
- Cursor (79,59), send 'A' → write at addr 4799, data 0x21. Then row 0 cleared (addr 0..79), cursor (0,0).
- BS at (0,7) → no strobe, cursor unchanged. BS at (3,7) → write at addr 562, data 0, cursor (2,7).
- `wr_allow` toggling 1-of-4 during a PUT with `clear_req` pulsed mid-PUT → the write lands only on a granted cycle, then a full CLEAR follows. The byte offered in the `clear_req` cycle is not accepted.

Source files
------------

// File: rtl/text_pkg.sv
// -----------------------------------------------------------------------------
// text_pkg
// Shared definitions for the VGA character buffer. Used by the write-side
// controller (text_writer) and by the character renderer that scans the
// buffer out.
//   CHARHRES / CHARVRES : character grid dimensions (80 x 60)
//   SPC                 : ASCII code stored as glyph index 0
//   ASCII_CR/LF/BS      : control codes the writer interprets
//   ADDR_W              : buffer address width (row*CHARHRES+col)
//   text_state_e        : writer FSM states
// -----------------------------------------------------------------------------
package text_pkg;

    localparam int CHARHRES = 80;
    localparam int CHARVRES = 60;
    localparam int CELLS    = CHARHRES * CHARVRES;
    localparam int ADDR_W   = 13;

    localparam logic [7:0] SPC      = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_BS = 8'h08;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PUT     = 2'd2,
        ST_LINECLR = 2'd3
    } text_state_e;

    // Bytes 0x20..0x7E have a glyph; everything else is control or ignored.
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= SPC) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_writer.sv
// -----------------------------------------------------------------------------
// text_writer
// Write-side controller for the 80x60 character buffer. Consumes an ASCII
// byte stream, maintains a cursor and converts characters and control codes
// (CR, LF, BS) into single-cycle buffer writes. Clears the whole buffer after
// reset or on clear_req, and clears each new line on LF or wrap. A write is
// only issued in cycles where the display side grants the port (wr_allow).
//
// Ports
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   char_valid  in   char_data holds a byte
//   char_data   in   ASCII byte
//   char_ready  out  byte accepted when char_valid & char_ready
//   clear_req   in   one-cycle pulse: clear buffer and home the cursor
//   wr_allow    in   buffer write port granted this cycle
//   wr_en       out  buffer write strobe
//   wr_addr     out  row*CHARHRES+col (registered)
//   wr_data     out  glyph index (registered)
//   cursor_x    out  current column
//   cursor_y    out  current row
//   busy        out  high in any state except IDLE
// -----------------------------------------------------------------------------
module text_writer
    import text_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    input  logic              clear_req,
    input  logic              wr_allow,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [6:0]        cursor_x,
    output logic [5:0]        cursor_y,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(CHARHRES);
    localparam logic [6:0]        LAST_COL  = 7'(CHARHRES - 1);
    localparam logic [5:0]        LAST_ROW  = 6'(CHARVRES - 1);

    text_state_e       state_q, state_d;
    logic [6:0]        col_q, col_d;
    logic [5:0]        row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [6:0]        cnt_q, cnt_d;
    logic              is_bs_q, is_bs_d;
    logic              clr_pend_q, clr_pend_d;

    // Cursor position one row down, wrapping to the top (no scrolling).
    logic [5:0]        row_next;
    logic [ADDR_W-1:0] base_next;
    logic [ADDR_W-1:0] cur_addr;
    logic              done;

    assign row_next  = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;
    assign base_next = (row_q == LAST_ROW) ? '0 : row_base_q + ROW_STEP;
    assign cur_addr  = row_base_q + {6'd0, col_q};

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and datapath next values
    // ---------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        is_bs_d    = is_bs_q;
        clr_pend_d = clr_pend_q;
        done       = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                // clear_req is deliberately ignored here: a clear is already running.
                if (wr_en) begin
                    if (addr_q == LAST_CELL) begin
                        state_d    = ST_IDLE;
                        col_d      = '0;
                        row_d      = '0;
                        row_base_d = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end

            ST_IDLE: begin
                if (clear_req) begin
                    // Clear wins over a byte offered in the same cycle.
                    state_d = ST_CLEAR;
                    addr_d  = '0;
                    data_d  = '0;
                end else if (char_valid) begin
                    if (is_printable(char_data)) begin
                        state_d = ST_PUT;
                        addr_d  = cur_addr;
                        data_d  = char_data - SPC;
                        is_bs_d = 1'b0;
                    end else if (char_data == ASCII_CR) begin
                        col_d = '0;
                    end else if (char_data == ASCII_LF) begin
                        state_d    = ST_LINECLR;
                        col_d      = '0;
                        row_d      = row_next;
                        row_base_d = base_next;
                        addr_d     = base_next;
                        data_d     = '0;
                        cnt_d      = '0;
                    end else if (char_data == ASCII_BS) begin
                        if (col_q != 7'd0) begin
                            state_d = ST_PUT;
                            col_d   = col_q - 7'd1;
                            addr_d  = cur_addr - 1'b1;
                            data_d  = '0;
                            is_bs_d = 1'b1;
                        end
                    end
                end
            end

            ST_PUT: begin
                if (clear_req) begin
                    clr_pend_d = 1'b1;
                end
                if (wr_en) begin
                    if (is_bs_q) begin
                        done = 1'b1;
                    end else if (col_q == LAST_COL) begin
                        // Writing the last column behaves like a line feed.
                        state_d    = ST_LINECLR;
                        col_d      = '0;
                        row_d      = row_next;
                        row_base_d = base_next;
                        addr_d     = base_next;
                        data_d     = '0;
                        cnt_d      = '0;
                    end else begin
                        col_d = col_q + 7'd1;
                        done  = 1'b1;
                    end
                end
            end

            ST_LINECLR: begin
                if (clear_req) begin
                    clr_pend_d = 1'b1;
                end
                if (wr_en) begin
                    if (cnt_q == LAST_COL) begin
                        done = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + 7'd1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end

            default: state_d = ST_CLEAR;
        endcase

        // A clear requested during PUT/LINECLR (including this very cycle)
        // is taken instead of returning to IDLE.
        if (done) begin
            if (clr_pend_q || clear_req) begin
                state_d    = ST_CLEAR;
                addr_d     = '0;
                data_d     = '0;
                clr_pend_d = 1'b0;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Datapath and cursor registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            is_bs_q    <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            is_bs_q    <= is_bs_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        wr_en      = (state_q != ST_IDLE) && wr_allow;
        char_ready = (state_q == ST_IDLE) && !clear_req && !clr_pend_q;
        busy       = (state_q != ST_IDLE);
        wr_addr    = addr_q;
        wr_data    = data_q;
        cursor_x   = col_q;
        cursor_y   = row_q;
    end

endmodule

// File: tb/tb_text_writer.sv
// -----------------------------------------------------------------------------
// tb_text_writer
// Self-checking bench for text_writer. A cursor model predicts every buffer
// write into exp_q when a byte is accepted; observed strobes are collected
// into obs_q each cycle and each test drains and compares both queues.
// -----------------------------------------------------------------------------
module tb_text_writer;

    localparam int CELLS = 4800;
    localparam int HRES  = 80;
    localparam int VRES  = 60;

    logic        clk;
    logic        rst;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        clear_req;
    logic        wr_allow;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic        busy;

    text_writer dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .wr_allow   (wr_allow),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;
    int allow_mode = 0;   // 0: always grant, 1: grant 1 cycle in 4, 2: never grant
    int bad_strobe = 0;
    int mx = 0;
    int my = 0;
    logic [20:0] exp_q[$];
    logic [20:0] obs_q[$];

    // One clock cycle: apply grant, sample outputs mid-cycle, wait for the next negedge.
    task automatic cycle(output bit acc);
        case (allow_mode)
            0:       wr_allow = 1'b1;
            1:       wr_allow = (cyc % 4 == 0);
            default: wr_allow = 1'b0;
        endcase
        #1;
        acc = (char_valid === 1'b1) && (char_ready === 1'b1);
        if (wr_en === 1'b1) begin
            obs_q.push_back({wr_addr, wr_data});
            if (wr_allow !== 1'b1) bad_strobe++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic push_row_clear(input int row);
        for (int c = 0; c < HRES; c++) exp_q.push_back({13'(row * HRES + c), 8'h00});
    endtask

    task automatic model_clear();
        for (int a = 0; a < CELLS; a++) exp_q.push_back({13'(a), 8'h00});
        mx = 0;
        my = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({13'(my * HRES + mx), b - 8'h20});
            if (mx == HRES - 1) begin
                mx = 0;
                my = (my + 1) % VRES;
                push_row_clear(my);
            end else begin
                mx++;
            end
        end else if (b == 8'h0D) begin
            mx = 0;
        end else if (b == 8'h0A) begin
            mx = 0;
            my = (my + 1) % VRES;
            push_row_clear(my);
        end else if (b == 8'h08) begin
            if (mx > 0) begin
                mx--;
                exp_q.push_back({13'(my * HRES + mx), 8'h00});
            end
        end
    endtask

    task automatic wait_idle(input int limit);
        bit acc;
        for (int i = 0; i < limit; i++) begin
            if (busy === 1'b0) break;
            cycle(acc);
        end
        nchk++;
        if (busy !== 1'b0) begin
            nfail++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, limit);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        acc = 1'b0;
        char_valid = 1'b1;
        char_data  = b;
        for (int i = 0; i < 200; i++) begin
            cycle(acc);
            if (acc) break;
        end
        char_valid = 1'b0;
        if (!acc) begin
            nchk++;
            nfail++;
            $display("FAIL accept_timeout: byte %h not accepted, required accept", b);
        end else begin
            model_byte(b);
        end
        wait_idle(30000);
    endtask

    task automatic test_reset();
        bit acc;
        logic [20:0] e, o;
        rst = 1'b1;
        allow_mode = 2;
        cycle(acc);
        cycle(acc);
        nchk++;
        if (wr_addr !== 13'd0 || wr_data !== 8'd0 || cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
            nfail++;
            $display("FAIL reset_regs: addr=%0d data=%h cur=(%0d,%0d), required 0,00,(0,0)",
                     wr_addr, wr_data, cursor_x, cursor_y);
        end
        nchk++;
        if (char_ready !== 1'b0 || busy !== 1'b1) begin
            nfail++;
            $display("FAIL reset_ctrl: ready=%b busy=%b, required 0 1", char_ready, busy);
        end
        obs_q.delete();
        exp_q.delete();
        rst = 1'b0;
        allow_mode = 0;
        model_clear();
        wait_idle(6000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nchk++;
            if (obs_q.size() == 0) begin
                nfail++;
                $display("FAIL reset_clear: no write, required addr %0d data %h", e[20:8], e[7:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    nfail++;
                    $display("FAIL reset_clear: addr %0d data %h, required addr %0d data %h",
                             o[20:8], o[7:0], e[20:8], e[7:0]);
                end
            end
        end
        nchk++;
        if (obs_q.size() != 0) begin
            nfail++;
            $display("FAIL reset_extra: %0d extra writes, required 0", obs_q.size());
            obs_q.delete();
        end
        nchk++;
        if (char_ready !== 1'b1 || cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
            nfail++;
            $display("FAIL reset_done: ready=%b cur=(%0d,%0d), required 1 (0,0)",
                     char_ready, cursor_x, cursor_y);
        end
    endtask

    task automatic test_hi();
        logic [20:0] e, o;
        send_byte("H");
        send_byte("i");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nchk++;
            if (obs_q.size() == 0) begin
                nfail++;
                $display("FAIL hi_write: no write, required addr %0d data %h", e[20:8], e[7:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    nfail++;
                    $display("FAIL hi_write: addr %0d data %h, required addr %0d data %h",
                             o[20:8], o[7:0], e[20:8], e[7:0]);
                end
            end
        end
        nchk++;
        if (obs_q.size() != 0 || cursor_x !== 7'd2 || cursor_y !== 6'd0) begin
            nfail++;
            $display("FAIL hi_cursor: extra=%0d cur=(%0d,%0d), required 0 (2,0)",
                     obs_q.size(), cursor_x, cursor_y);
            obs_q.delete();
        end
    endtask

    task automatic test_linefeed();
        logic [20:0] e, o;
        send_byte(8'h0D);
        for (int i = 0; i < 3; i++) send_byte(8'h0A);
        for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i));
        nchk++;
        if (cursor_x !== 7'd5 || cursor_y !== 6'd3) begin
            nfail++;
            $display("FAIL lf_setup: cur=(%0d,%0d), required (5,3)", cursor_x, cursor_y);
        end
        send_byte(8'h0A);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nchk++;
            if (obs_q.size() == 0) begin
                nfail++;
                $display("FAIL lf_write: no write, required addr %0d data %h", e[20:8], e[7:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    nfail++;
                    $display("FAIL lf_write: addr %0d data %h, required addr %0d data %h",
                             o[20:8], o[7:0], e[20:8], e[7:0]);
                end
            end
        end
        nchk++;
        if (obs_q.size() != 0 || cursor_x !== 7'd0 || cursor_y !== 6'd4) begin
            nfail++;
            $display("FAIL lf_cursor: extra=%0d cur=(%0d,%0d), required 0 (0,4)",
                     obs_q.size(), cursor_x, cursor_y);
            obs_q.delete();
        end
    endtask

    task automatic test_wrap();
        logic [20:0] e, o;
        for (int i = 0; i < 55; i++) send_byte(8'h0A);
        for (int i = 0; i < 79; i++) send_byte(8'h30 + 8'(i % 10));
        nchk++;
        if (cursor_x !== 7'd79 || cursor_y !== 6'd59) begin
            nfail++;
            $display("FAIL wrap_setup: cur=(%0d,%0d), required (79,59)", cursor_x, cursor_y);
        end
        send_byte("A");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nchk++;
            if (obs_q.size() == 0) begin
                nfail++;
                $display("FAIL wrap_write: no write, required addr %0d data %h", e[20:8], e[7:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    nfail++;
                    $display("FAIL wrap_write: addr %0d data %h, required addr %0d data %h",
                             o[20:8], o[7:0], e[20:8], e[7:0]);
                end
            end
        end
        nchk++;
        if (obs_q.size() != 0 || cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
            nfail++;
            $display("FAIL wrap_cursor: extra=%0d cur=(%0d,%0d), required 0 (0,0)",
                     obs_q.size(), cursor_x, cursor_y);
            obs_q.delete();
        end
    endtask

    task automatic test_backspace();
        logic [20:0] e, o;
        for (int i = 0; i < 7; i++) send_byte(8'h0A);
        send_byte(8'h08);
        nchk++;
        if (cursor_x !== 7'd0 || cursor_y !== 6'd7) begin
            nfail++;
            $display("FAIL bs_col0: cur=(%0d,%0d), required (0,7)", cursor_x, cursor_y);
        end
        send_byte("x");
        send_byte("y");
        send_byte("z");
        send_byte(8'h08);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nchk++;
            if (obs_q.size() == 0) begin
                nfail++;
                $display("FAIL bs_write: no write, required addr %0d data %h", e[20:8], e[7:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    nfail++;
                    $display("FAIL bs_write: addr %0d data %h, required addr %0d data %h",
                             o[20:8], o[7:0], e[20:8], e[7:0]);
                end
            end
        end
        nchk++;
        if (obs_q.size() != 0 || cursor_x !== 7'd2 || cursor_y !== 6'd7) begin
            nfail++;
            $display("FAIL bs_cursor: extra=%0d cur=(%0d,%0d), required 0 (2,7)",
                     obs_q.size(), cursor_x, cursor_y);
            obs_q.delete();
        end
    endtask

    task automatic test_clear_mid_put();
        bit acc;
        logic [20:0] e, o;
        allow_mode = 1;
        bad_strobe = 0;
        acc = 1'b0;
        char_valid = 1'b1;
        char_data  = "Q";
        for (int i = 0; i < 200; i++) begin
            cycle(acc);
            if (acc) break;
        end
        nchk++;
        if (!acc) begin
            nfail++;
            $display("FAIL midput_accept: byte 51 not accepted, required accept");
        end
        model_byte("Q");
        // Offer a new byte together with the clear pulse while the PUT is pending.
        char_data = "Z";
        clear_req = 1'b1;
        cycle(acc);
        clear_req  = 1'b0;
        char_valid = 1'b0;
        nchk++;
        if (acc) begin
            nfail++;
            $display("FAIL midput_byte: accepted=1, required 0");
        end
        model_clear();
        wait_idle(25000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nchk++;
            if (obs_q.size() == 0) begin
                nfail++;
                $display("FAIL midput_write: no write, required addr %0d data %h", e[20:8], e[7:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    nfail++;
                    $display("FAIL midput_write: addr %0d data %h, required addr %0d data %h",
                             o[20:8], o[7:0], e[20:8], e[7:0]);
                end
            end
        end
        nchk++;
        if (obs_q.size() != 0 || bad_strobe != 0) begin
            nfail++;
            $display("FAIL midput_strobes: extra=%0d ungranted=%0d, required 0 0",
                     obs_q.size(), bad_strobe);
            obs_q.delete();
        end
        nchk++;
        if (cursor_x !== 7'd0 || cursor_y !== 6'd0 || char_ready !== 1'b1) begin
            nfail++;
            $display("FAIL midput_cursor: cur=(%0d,%0d) ready=%b, required (0,0) 1",
                     cursor_x, cursor_y, char_ready);
        end
        allow_mode = 0;
    endtask

    task automatic test_clear_idle();
        bit acc;
        logic [20:0] e, o;
        send_byte("M");
        char_valid = 1'b1;
        char_data  = "K";
        clear_req  = 1'b1;
        cycle(acc);
        clear_req  = 1'b0;
        char_valid = 1'b0;
        nchk++;
        if (acc) begin
            nfail++;
            $display("FAIL idleclr_byte: accepted=1, required 0");
        end
        model_clear();
        wait_idle(6000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nchk++;
            if (obs_q.size() == 0) begin
                nfail++;
                $display("FAIL idleclr_write: no write, required addr %0d data %h", e[20:8], e[7:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    nfail++;
                    $display("FAIL idleclr_write: addr %0d data %h, required addr %0d data %h",
                             o[20:8], o[7:0], e[20:8], e[7:0]);
                end
            end
        end
        nchk++;
        if (obs_q.size() != 0 || cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
            nfail++;
            $display("FAIL idleclr_cursor: extra=%0d cur=(%0d,%0d), required 0 (0,0)",
                     obs_q.size(), cursor_x, cursor_y);
            obs_q.delete();
        end
    endtask

    initial begin
        rst        = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        clear_req  = 1'b0;
        wr_allow   = 1'b0;
        @(negedge clk);
        test_reset();
        test_hi();
        test_linefeed();
        test_wrap();
        test_backspace();
        test_clear_mid_put();
        test_clear_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
